// File: rtl/sync_queue_param_pkg.sv
// -----------------------------------------------------------------------------
// queue_pkg
//   Shared definitions for the parametrised single-clock queue family.
//   - addr_w()/count_w(): pointer and occupancy widths derived from a depth.
//   - `QUEUE_COUNT_T(depth): packed type wide enough to hold 0..depth.
//     A package cannot hold a parameterised typedef, so callers expand it
//     with their own DEPTH.
//   - queue_status_e: bit positions for shared status buses
//     (empty, full, almost-full, almost-empty, overflow).
// -----------------------------------------------------------------------------
`ifndef QUEUE_PKG_SV
`define QUEUE_PKG_SV

`define QUEUE_COUNT_T(depth) logic [$clog2(depth):0]

package queue_pkg;

    // Pointer width; a depth below 2 still needs one address bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width: one extra bit so the value DEPTH is representable.
    function automatic int unsigned count_w(input int unsigned depth);
        return addr_w(depth) + 1;
    endfunction

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_FULL  = 3'd1,
        ST_AF    = 3'd2,
        ST_AE    = 3'd3,
        ST_OVF   = 3'd4
    } queue_status_e;

    localparam int unsigned STATUS_W = 5;

endpackage

`endif

// File: rtl/sync_queue_param_ram_sdp_sync.sv
// -----------------------------------------------------------------------------
// ram_sdp_sync
//   Simple dual-port RAM, WIDTH x DEPTH, one write port and one read port on
//   the same clock. The read data is registered (one-cycle read latency).
//   Read-during-write to the same address returns an undefined mix of old and
//   new data; the queue never relies on that result.
//
// Ports
//   clk_i    in   1      clock
//   we_i     in   1      write enable
//   waddr_i  in   AW     write address
//   wdata_i  in   WIDTH  write data
//   raddr_i  in   AW     read address (sampled on the rising edge)
//   rdata_o  out  WIDTH  registered read data
// -----------------------------------------------------------------------------
module ram_sdp_sync
    import queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset: the array and its output register map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_queue_param.sv
// -----------------------------------------------------------------------------
// sync_queue_param
//   Parametrised single-clock FIFO with a registered-read RAM, empty-queue
//   bypass, almost-full/almost-empty flags, sticky overflow and flush.
//
// Handshake (both sides): a transfer happens in a cycle where valid and ready
//   are both high at the rising edge. io_enq_ready depends only on state
//   (~full); io_deq_valid depends only on state (~empty). Neither side ever
//   sees a combinational path from the other, and a word enqueued in cycle N
//   is first visible on io_deq_bits in cycle N+1.
//
// Ports
//   clock            in   1      clock, all state on rising edge
//   reset            in   1      synchronous, active-high
//   io_enq_valid     in   1      producer has data
//   io_enq_ready     out  1      queue not full
//   io_enq_bits      in   WIDTH  write data
//   io_deq_ready     in   1      consumer accepts head
//   io_deq_valid     out  1      queue not empty
//   io_deq_bits      out  WIDTH  head data, valid while io_deq_valid
//   io_count         out  AW+1   occupancy 0..DEPTH
//   io_almost_full   out  1      io_count >= AF_THRESH
//   io_almost_empty  out  1      io_count <= AE_THRESH
//   io_overflow      out  1      sticky: enq attempted while full
//   io_high_water    out  AW+1   peak occupancy since reset/flush
//   io_flush         in   1      synchronous discard of all contents
//
// Configuration
//   QUEUE_HIGH_WATER_EN  when defined, io_high_water is a register tracking
//                        peak occupancy; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module sync_queue_param
    import queue_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = 56,
    parameter int AE_THRESH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_enq_valid,
    output logic                   io_enq_ready,
    input  logic [WIDTH-1:0]       io_enq_bits,
    input  logic                   io_deq_ready,
    output logic                   io_deq_valid,
    output logic [WIDTH-1:0]       io_deq_bits,
    output logic [$clog2(DEPTH):0] io_count,
    output logic                   io_almost_full,
    output logic                   io_almost_empty,
    output logic                   io_overflow,
    output logic [$clog2(DEPTH):0] io_high_water,
    input  logic                   io_flush
);

    localparam int AW = addr_w(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef `QUEUE_COUNT_T(DEPTH) count_t;

    localparam count_t AF_LEVEL = count_t'(AF_THRESH);
    localparam count_t AE_LEVEL = count_t'(AE_THRESH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ptr_t             enq_ptr_q,     enq_ptr_d;
    ptr_t             deq_ptr_q,     deq_ptr_d;
    logic             maybe_full_q,  maybe_full_d;
    logic             overflow_q,    overflow_d;
    logic             bypass_q,      bypass_d;
    logic [WIDTH-1:0] bypass_data_q, bypass_data_d;

    // ------------------------------------------------------------------
    // Status and handshake
    // ------------------------------------------------------------------
    logic             ptr_match;
    logic             full;
    logic             empty;
    logic             do_enq;
    logic             do_deq;
    ptr_t             r_addr;
    logic [WIDTH-1:0] ram_rdata;

    always_comb begin
        ptr_match = (enq_ptr_q == deq_ptr_q);
        full      = ptr_match &  maybe_full_q;
        empty     = ptr_match & ~maybe_full_q;
        do_enq    = io_enq_valid & ~full;
        do_deq    = io_deq_ready & ~empty;
        // Read one ahead when popping so the next head is registered in
        // the RAM output by the following cycle.
        r_addr    = do_deq ? (deq_ptr_q + ptr_t'(1)) : deq_ptr_q;
    end

    // ------------------------------------------------------------------
    // Next-state: pointers, maybe_full, overflow
    // ------------------------------------------------------------------
    always_comb begin
        enq_ptr_d    = enq_ptr_q;
        deq_ptr_d    = deq_ptr_q;
        maybe_full_d = maybe_full_q;
        overflow_d   = overflow_q | (io_enq_valid & full);

        if (do_enq) begin
            enq_ptr_d = enq_ptr_q + ptr_t'(1);
        end
        if (do_deq) begin
            deq_ptr_d = deq_ptr_q + ptr_t'(1);
        end
        // Pointers can only become equal-and-full through a net enqueue.
        if (do_enq != do_deq) begin
            maybe_full_d = do_enq;
        end

        // Flush overrides any same-cycle transfer. A RAM write may still
        // happen this cycle, but the slot is unreachable afterwards.
        if (io_flush) begin
            enq_ptr_d    = '0;
            deq_ptr_d    = '0;
            maybe_full_d = 1'b0;
            overflow_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Bypass: when the slot being written is the slot being read this
    // cycle, the RAM output is undefined next cycle, so the write data is
    // captured here and substituted for it.
    // ------------------------------------------------------------------
    always_comb begin
        bypass_d      = do_enq & (enq_ptr_q == r_addr);
        bypass_data_d = bypass_data_q;
        if (bypass_d) begin
            bypass_data_d = io_enq_bits;
        end
        if (io_flush) begin
            bypass_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            enq_ptr_q    <= '0;
            deq_ptr_q    <= '0;
            maybe_full_q <= 1'b0;
            overflow_q   <= 1'b0;
            bypass_q     <= 1'b0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
            overflow_q   <= overflow_d;
            bypass_q     <= bypass_d;
        end
    end

    // Data-only register; its content is ignored unless bypass_q is set.
    always_ff @(posedge clock) begin
        bypass_data_q <= bypass_data_d;
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    ram_sdp_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (do_enq),
        .waddr_i (enq_ptr_q),
        .wdata_i (io_enq_bits),
        .raddr_i (r_addr),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The pointer difference wraps modulo 2^AW; the full bit supplies the
    // top bit so the value DEPTH appears only when actually full.
    assign io_count        = {full, ptr_t'(enq_ptr_q - deq_ptr_q)};
    assign io_enq_ready    = ~full;
    assign io_deq_valid    = ~empty;
    assign io_deq_bits     = bypass_q ? bypass_data_q : ram_rdata;
    assign io_almost_full  = (io_count >= AF_LEVEL);
    assign io_almost_empty = (io_count <= AE_LEVEL);
    assign io_overflow     = overflow_q;

`ifdef QUEUE_HIGH_WATER_EN
    count_t high_water_q, high_water_d;
    count_t count_d;
    logic   full_d;

    // Track the occupancy that will be visible next cycle so the peak
    // register and io_count change on the same edge.
    always_comb begin
        full_d       = (enq_ptr_d == deq_ptr_d) & maybe_full_d;
        count_d      = {full_d, ptr_t'(enq_ptr_d - deq_ptr_d)};
        high_water_d = (count_d > high_water_q) ? count_d : high_water_q;
        if (io_flush) begin
            high_water_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            high_water_q <= '0;
        end else begin
            high_water_q <= high_water_d;
        end
    end

    assign io_high_water = high_water_q;
`else
    assign io_high_water = '0;
`endif

endmodule

// File: tb/tb_sync_queue_param.sv
module tb_sync_queue_param;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

`ifdef QUEUE_HIGH_WATER_EN
  localparam bit HW_EN = 1'b1;
`else
  localparam bit HW_EN = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic         io_enq_valid;
  logic         io_enq_ready;
  logic [W-1:0] io_enq_bits;
  logic         io_deq_ready;
  logic         io_deq_valid;
  logic [W-1:0] io_deq_bits;
  logic [3:0]   io_count;
  logic         io_almost_full;
  logic         io_almost_empty;
  logic         io_overflow;
  logic [3:0]   io_high_water;
  logic         io_flush;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_q[$];

  sync_queue_param #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io_enq_valid    (io_enq_valid),
    .io_enq_ready    (io_enq_ready),
    .io_enq_bits     (io_enq_bits),
    .io_deq_ready    (io_deq_ready),
    .io_deq_valid    (io_deq_valid),
    .io_deq_bits     (io_deq_bits),
    .io_count        (io_count),
    .io_almost_full  (io_almost_full),
    .io_almost_empty (io_almost_empty),
    .io_overflow     (io_overflow),
    .io_high_water   (io_high_water),
    .io_flush        (io_flush)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b0;
    io_flush     = 1'b0;
    tick();
    reset        = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d);
    io_enq_valid = 1'b1;
    io_enq_bits  = d;
    tick();
    io_enq_valid = 1'b0;
  endtask

  task automatic pop();
    io_deq_ready = 1'b1;
    tick();
    io_deq_ready = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    push(16'h5555);
    push(16'h6666);
    do_reset();
    n_checks++;
    if (io_enq_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_enq_ready got %0b want 1", io_enq_ready);
    end
    n_checks++;
    if (io_deq_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_deq_valid got %0b want 0", io_deq_valid);
    end
    n_checks++;
    if (io_count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count got %0d want 0", io_count);
    end
    n_checks++;
    if ({io_almost_empty, io_almost_full, io_overflow} !== 3'b100) begin
      n_fail++; $display("FAIL reset_flags got ae/af/ovf=%03b want 100",
                         {io_almost_empty, io_almost_full, io_overflow});
    end
    n_checks++;
    if (io_high_water !== 4'd0) begin
      n_fail++; $display("FAIL reset_high_water got %0d want 0", io_high_water);
    end
  endtask

  task automatic test_single();
    do_reset();
    push(16'h1111);
    n_checks++;
    if (io_deq_valid !== 1'b1 || io_deq_bits !== 16'h1111) begin
      n_fail++; $display("FAIL single_head got v=%0b d=%h want v=1 d=1111",
                         io_deq_valid, io_deq_bits);
    end
    n_checks++;
    if (io_count !== 4'd1 || io_almost_empty !== 1'b1) begin
      n_fail++; $display("FAIL single_count got cnt=%0d ae=%0b want cnt=1 ae=1",
                         io_count, io_almost_empty);
    end
    pop();
    n_checks++;
    if (io_count !== 4'd0 || io_deq_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pop got cnt=%0d v=%0b want cnt=0 v=0",
                         io_count, io_deq_valid);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < D; i++) begin
      push(W'(i));
    end
    n_checks++;
    if (io_count !== 4'd8 || io_enq_ready !== 1'b0 || io_almost_full !== 1'b1) begin
      n_fail++; $display("FAIL full_state got cnt=%0d rdy=%0b af=%0b want cnt=8 rdy=0 af=1",
                         io_count, io_enq_ready, io_almost_full);
    end
    n_checks++;
    if (io_overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_no_ovf got %0b want 0", io_overflow);
    end
    push(16'hDEAD);
    n_checks++;
    if (io_overflow !== 1'b1 || io_count !== 4'd8) begin
      n_fail++; $display("FAIL overflow got ovf=%0b cnt=%0d want ovf=1 cnt=8",
                         io_overflow, io_count);
    end
    for (int i = 0; i < D; i++) begin
      n_checks++;
      if (io_deq_valid !== 1'b1 || io_deq_bits !== W'(i)) begin
        n_fail++; $display("FAIL drain_order[%0d] got v=%0b d=%h want v=1 d=%h",
                           i, io_deq_valid, io_deq_bits, W'(i));
      end
      if (i == 3) begin
        // count is 5 here: below AF=6, above AE=2
        n_checks++;
        if (io_count !== 4'd5 || io_almost_full !== 1'b0 || io_almost_empty !== 1'b0) begin
          n_fail++; $display("FAIL thresh_5 got cnt=%0d af=%0b ae=%0b want 5 0 0",
                             io_count, io_almost_full, io_almost_empty);
        end
      end
      if (i == 6) begin
        // count is 2: at AE threshold
        n_checks++;
        if (io_count !== 4'd2 || io_almost_empty !== 1'b1) begin
          n_fail++; $display("FAIL thresh_2 got cnt=%0d ae=%0b want 2 1",
                             io_count, io_almost_empty);
        end
      end
      pop();
    end
    n_checks++;
    if (io_count !== 4'd0 || io_deq_valid !== 1'b0 || io_overflow !== 1'b1) begin
      n_fail++; $display("FAIL drained got cnt=%0d v=%0b ovf=%0b want 0 0 1",
                         io_count, io_deq_valid, io_overflow);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] d;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      d = 16'h0200 + W'(i);
      push(d);
      exp_q.push_back(d);
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (io_deq_valid !== 1'b1 || io_deq_bits !== exp_q[0]) begin
        n_fail++; $display("FAIL stream_head[%0d] got v=%0b d=%h want v=1 d=%h",
                           i, io_deq_valid, io_deq_bits, exp_q[0]);
      end
      d = 16'h0100 + W'(i);
      io_enq_valid = 1'b1;
      io_enq_bits  = d;
      io_deq_ready = 1'b1;
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(d);
      n_checks++;
      if (io_count !== 4'd4) begin
        n_fail++; $display("FAIL stream_count[%0d] got %0d want 4", i, io_count);
      end
    end
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b0;
    while (exp_q.size() > 0) begin
      n_checks++;
      if (io_deq_valid !== 1'b1 || io_deq_bits !== exp_q[0]) begin
        n_fail++; $display("FAIL stream_tail got v=%0b d=%h want v=1 d=%h",
                           io_deq_valid, io_deq_bits, exp_q[0]);
      end
      pop();
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (io_count !== 4'd0) begin
      n_fail++; $display("FAIL stream_end_count got %0d want 0", io_count);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    io_deq_ready = 1'b1;
    io_enq_valid = 1'b1;
    io_enq_bits  = 16'hABCD;
    tick();
    io_enq_valid = 1'b0;
    // deq was blocked in the empty cycle, so the word is still held
    n_checks++;
    if (io_deq_valid !== 1'b1 || io_deq_bits !== 16'hABCD || io_count !== 4'd1) begin
      n_fail++; $display("FAIL bypass_head got v=%0b d=%h cnt=%0d want 1 abcd 1",
                         io_deq_valid, io_deq_bits, io_count);
    end
    tick();
    io_deq_ready = 1'b0;
    n_checks++;
    if (io_count !== 4'd0 || io_deq_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_pop got cnt=%0d v=%0b want 0 0",
                         io_count, io_deq_valid);
    end
  endtask

  task automatic test_back_to_back();
    // one element, then enq+deq: the new word lands on the slot being read
    do_reset();
    push(16'h0A0A);
    io_enq_valid = 1'b1;
    io_enq_bits  = 16'h0B0B;
    io_deq_ready = 1'b1;
    tick();
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b0;
    n_checks++;
    if (io_deq_valid !== 1'b1 || io_deq_bits !== 16'h0B0B || io_count !== 4'd1) begin
      n_fail++; $display("FAIL b2b_bypass got v=%0b d=%h cnt=%0d want 1 0b0b 1",
                         io_deq_valid, io_deq_bits, io_count);
    end
    tick();
    n_checks++;
    if (io_deq_bits !== 16'h0B0B) begin
      n_fail++; $display("FAIL b2b_hold got d=%h want 0b0b", io_deq_bits);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(16'h0300 + W'(i));
    end
    n_checks++;
    if (io_count !== 4'd5) begin
      n_fail++; $display("FAIL flush_pre_count got %0d want 5", io_count);
    end
    io_enq_valid = 1'b1;
    io_enq_bits  = 16'h9999;
    io_flush     = 1'b1;
    tick();
    io_enq_valid = 1'b0;
    io_flush     = 1'b0;
    n_checks++;
    if (io_count !== 4'd0 || io_deq_valid !== 1'b0 || io_overflow !== 1'b0) begin
      n_fail++; $display("FAIL flush_state got cnt=%0d v=%0b ovf=%0b want 0 0 0",
                         io_count, io_deq_valid, io_overflow);
    end
    push(16'h0042);
    n_checks++;
    if (io_deq_valid !== 1'b1 || io_deq_bits !== 16'h0042) begin
      n_fail++; $display("FAIL flush_after got v=%0b d=%h want 1 0042",
                         io_deq_valid, io_deq_bits);
    end
    pop();
    // flush also clears a sticky overflow
    for (int i = 0; i < D + 1; i++) begin
      push(W'(i));
    end
    n_checks++;
    if (io_overflow !== 1'b1) begin
      n_fail++; $display("FAIL flush_ovf_set got %0b want 1", io_overflow);
    end
    io_flush = 1'b1;
    tick();
    io_flush = 1'b0;
    n_checks++;
    if (io_overflow !== 1'b0 || io_count !== 4'd0 || io_enq_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_ovf_clr got ovf=%0b cnt=%0d rdy=%0b want 0 0 1",
                         io_overflow, io_count, io_enq_ready);
    end
  endtask

  task automatic test_high_water();
    logic [3:0] exp_hw;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      push(W'(i));
    end
    for (int i = 0; i < 7; i++) begin
      pop();
    end
    exp_hw = HW_EN ? 4'd7 : 4'd0;
    n_checks++;
    if (io_high_water !== exp_hw || io_count !== 4'd0) begin
      n_fail++; $display("FAIL high_water_peak got hw=%0d cnt=%0d want hw=%0d cnt=0",
                         io_high_water, io_count, exp_hw);
    end
    io_flush = 1'b1;
    tick();
    io_flush = 1'b0;
    n_checks++;
    if (io_high_water !== 4'd0) begin
      n_fail++; $display("FAIL high_water_flush got %0d want 0", io_high_water);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    io_enq_valid = 1'b0;
    io_enq_bits  = '0;
    io_deq_ready = 1'b0;
    io_flush     = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    test_reset();
    test_single();
    test_fill_overflow();
    test_stream();
    test_bypass();
    test_back_to_back();
    test_flush();
    test_high_water();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
